// File: rtl/mux4_arb_pkg.sv
// Shared constants and types for the four-way round-robin arbiter.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  // Mux select encoding, {s1,s0}
  localparam logic [SEL_W-1:0] SEL_A = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B = 2'b01;
  localparam logic [SEL_W-1:0] SEL_C = 2'b10;
  localparam logic [SEL_W-1:0] SEL_D = 2'b11;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } arb_state_e;

endpackage

// File: rtl/mux4t01.sv
// 4:1 word mux, select {s1,s0}: 00=a, 01=b, 10=c, 11=d.
module mux4t01
  import mux4_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);

  // Decode the two select bits onto the four inputs
  always_comb begin
    y = a;
    case ({s1, s0})
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Pointer-rotated priority picker: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester to ptr wins last
  always_comb begin
    any = |req;
    win = ptr;
    idx = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        win = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux among four valid/ready requesters,
// with a registered valid/ready output stage.
// Optional macro ARB_LOCK_EN adds req_lock: a locked winner keeps priority for up to
// HOLD_MAX consecutive beats.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 16
`ifdef ARB_LOCK_EN
  ,
  parameter int unsigned HOLD_MAX = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [WIDTH-1:0]   req_data_a,
  input  logic [WIDTH-1:0]   req_data_b,
  input  logic [WIDTH-1:0]   req_data_c,
  input  logic [WIDTH-1:0]   req_data_d,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] req_lock,
`endif
  output logic [NUM_REQ-1:0] req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_s1,
  output logic               out_s0
);

  arb_state_e       state_q;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] win;
  logic [WIDTH-1:0] mux_y;
  logic             any;
  logic             load;
  logic             accept;

  rr_pick4 u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .any (any),
    .win (win)
  );

  mux4t01 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a  (req_data_a),
    .b  (req_data_b),
    .c  (req_data_c),
    .d  (req_data_d),
    .s1 (win[1]),
    .s0 (win[0]),
    .y  (mux_y)
  );

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_s1    = sel_q[1];
  assign out_s0    = sel_q[0];
  assign load      = !out_valid || out_ready;
  // rst_n gates the grant so nothing is accepted while reset is held
  assign accept    = rst_n && load && any;
  assign req_ready = accept ? ({{(NUM_REQ - 1){1'b0}}, 1'b1} << win) : '0;

`ifdef ARB_LOCK_EN
  logic [7:0] hold_q, hold_d;
  logic [8:0] run;

  // Beat count of the current winner; a winner other than the held ptr starts afresh
  always_comb begin
    run = (win == ptr_q) ? ({1'b0, hold_q} + 9'd1) : 9'd1;
    if (req_lock[win] && (run < 9'(HOLD_MAX))) begin
      ptr_d  = win;
      hold_d = run[7:0];
    end else begin
      ptr_d  = win + 2'd1;
      hold_d = '0;
    end
  end
`else
  // Priority moves to the requester after the winner
  always_comb begin
    ptr_d = win + 2'd1;
  end
`endif

  // Output stage FSM with captured word, source select and priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= SEL_A;
      ptr_q   <= SEL_A;
`ifdef ARB_LOCK_EN
      hold_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_q <= ST_FULL;
        ST_FULL:  if (out_ready && !accept) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
      if (accept) begin
        data_q <= mux_y;
        sel_q  <= win;
        ptr_q  <= ptr_d;
`ifdef ARB_LOCK_EN
        hold_q <= hold_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: per-cycle reference model plus directed checks.
module tb_mux4_rr_arbiter;

  localparam int HOLD = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data_a, req_data_b, req_data_c, req_data_d;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_s1, out_s0;
`ifdef ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif

  int checks;
  int fails;

  mux4_rr_arbiter #(
    .WIDTH    (16)
`ifdef ARB_LOCK_EN
    ,
    .HOLD_MAX (HOLD)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data_a (req_data_a),
    .req_data_b (req_data_b),
    .req_data_c (req_data_c),
    .req_data_d (req_data_d),
`ifdef ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_s1     (out_s1),
    .out_s0     (out_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input int i);
    case (i)
      0:       return req_data_a;
      1:       return req_data_b;
      2:       return req_data_c;
      default: return req_data_d;
    endcase
  endfunction

  // Reference model: what is in the output register and where priority starts
  logic        m_valid;
  logic [15:0] m_data;
  int          m_src;
  int          m_ptr;
  int          m_last;
  int          m_run;

  // Compare DUT against the model mid-cycle, then advance the model for the next edge
  always @(negedge clk) begin
    int w;
    int idx;
    logic [3:0] exp_rr;
    if (!rst_n) begin
      chk("m_rst_valid", 32'(out_valid), 32'd0);
      chk("m_rst_data", 32'(out_data), 32'd0);
      chk("m_rst_ready", 32'(req_ready), 32'd0);
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
      m_last  = -1;
      m_run   = 0;
    end else begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (w < 0 && req_valid[idx]) w = idx;
      end
      exp_rr = ((!m_valid || out_ready) && w >= 0) ? (4'b0001 << w) : 4'b0000;
      chk("m_req_ready", 32'(req_ready), 32'(exp_rr));
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("m_out_data", 32'(out_data), 32'(m_data));
        chk("m_out_sel", 32'({out_s1, out_s0}), 32'(m_src));
      end
      if (exp_rr != 4'b0000) begin
        m_valid = 1'b1;
        m_data  = word_of(w);
        m_src   = w;
        m_run   = (w == m_last) ? m_run + 1 : 1;
        m_last  = w;
        m_ptr   = (w + 1) % 4;
`ifdef ARB_LOCK_EN
        if (req_lock[w] && m_run < HOLD) m_ptr = w;
        else m_run = 0;
`endif
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int src, input logic [15:0] data);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, 32'(out_data), 32'(data));
    chk({name, "_sel"}, 32'({out_s1, out_s0}), 32'(src));
  endtask

  initial begin
    checks     = 0;
    fails      = 0;
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    out_ready  = 1'b0;
    req_data_a = 16'h000A;
    req_data_b = 16'h000B;
    req_data_c = 16'h000C;
    req_data_d = 16'h000D;
`ifdef ARB_LOCK_EN
    req_lock   = 4'b0000;
`endif
    repeat (2) cyc();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);

    // All four valid: A first, then strict rotation, one word per cycle
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("first_grant_a", 32'(req_ready), 32'h1);
    cyc(); expect_out("rr0_a", 0, 16'h000A);
    cyc(); expect_out("rr1_b", 1, 16'h000B);
    cyc(); expect_out("rr2_c", 2, 16'h000C);
    cyc(); expect_out("rr3_d", 3, 16'h000D);
    cyc(); expect_out("rr4_a", 0, 16'h000A);

    // Backpressure with B and C waiting: word held, nothing accepted
    req_valid = 4'b0110;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("stall_hold", 0, 16'h000A);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_grant_b", 32'(req_ready), 32'b0010);
    cyc(); expect_out("release_b", 1, 16'h000B);
    cyc(); expect_out("release_c", 2, 16'h000C);

    // Only D: D every cycle, pointer wraps to A
    req_valid = 4'b1000;
    cyc(); expect_out("sparse_d0", 3, 16'h000D);
    cyc(); expect_out("sparse_d1", 3, 16'h000D);
    req_valid = 4'b1001;
    #1;
    chk("wrap_grant_a", 32'(req_ready), 32'b0001);
    cyc(); expect_out("wrap_a", 0, 16'h000A);
    chk("wrap_grant_d", 32'(req_ready), 32'b1000);
    cyc(); expect_out("wrap_d", 3, 16'h000D);

    // Drain: one word from C, then empty
    req_valid = 4'b0100;
    cyc(); expect_out("drain_c", 2, 16'h000C);
    req_valid = 4'b0000;
    cyc(); chk("drain_empty0", 32'(out_valid), 32'd0);
    cyc(); chk("drain_empty1", 32'(out_valid), 32'd0);

    // Reset mid-transfer with pointer at D: everything clears, A wins afterwards
    req_valid = 4'b0100;
    out_ready = 1'b0;
    cyc(); expect_out("pre_reset_c", 2, 16'h000C);
    req_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc(); expect_out("post_reset_a", 0, 16'h000A);

`ifdef ARB_LOCK_EN
    // Locked B with a 3-beat limit sharing with A
    rst_n = 1'b0;
    cyc();
    rst_n     = 1'b1;
    req_valid = 4'b0011;
    req_lock  = 4'b0010;
    begin
      int seq [8] = '{0, 1, 1, 1, 0, 1, 1, 1};
      for (int i = 0; i < 8; i++) begin
        cyc();
        expect_out("lock_seq", seq[i], word_of(seq[i]));
      end
    end
    req_lock = 4'b0000;
`endif

    req_valid = 4'b0000;
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
